div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 restoring divider in the EX stage, directly downstream of the decode/control stage.
- Consumes the div and div_signed bits of the execute control bundle, plus forwarded rs/rt operands.
- Produces quotient (LO) and remainder (HI), and returns a one-cycle complete pulse to decode.
- Decode holds mfhi/mflo/mthi/mtlo until that pulse arrives.

Parameters:
DATA_W, 32, operand/result width; iteration count equals DATA_W.

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous active-low reset
div  in  1  start request, qualified by decode (exe_ctrl div bit)
div_signed  in  1  1 = DIV (two's complement), 0 = DIVU
dividend  in  DATA_W  rs operand, sampled on accepted start
divisor  in  DATA_W  rt operand, sampled on accepted start
sweap  in  1  pipeline flush (exception/eret); aborts the operation in flight
busy  out  1  high from the cycle after an accepted start until complete or abort
complete  out  1  one-cycle pulse: results valid
quotient  out  DATA_W  LO result, held until the next accepted start
remainder  out  DATA_W  HI result, held until the next accepted start

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, count=0, busy=0, complete=0.
  - quotient=0, remainder=0; all internal registers cleared.
  - A reset mid-operation discards the operation; no complete is issued.
- States:
  - IDLE -> RUN on an accepted start.
  - RUN -> DONE when count reaches DATA_W-1 on its iteration.
  - DONE -> IDLE unconditionally after one cycle.
  - Any state -> IDLE on sweap.
- Start acceptance: div=1 & sweap=0 & state==IDLE.
  - div while busy (RUN or DONE) is ignored; decode's stall guarantees it does not occur. Verification asserts it.
  - Start and sweap in the same cycle: sweap wins, nothing is captured.
- Capture at start:
  - For signed operations, form |dividend| and |divisor|.
  - Record q_neg = sign(dividend) ^ sign(divisor) and r_neg = sign(dividend).
  - Unsigned operations take operands as-is, with q_neg = r_neg = 0.
- RUN, one restoring step per cycle (DATA_W cycles, count 0..DATA_W-1):
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor magnitude from the upper DATA_W+1 bits.
  - If the result is non-negative, keep it and set the quo LSB to 1.
- DONE:
  - quotient = q_neg ? -quo : quo; remainder = r_neg ? -rem : rem. Both registered.
  - complete=1 for exactly this cycle; busy falls to 0 on the same cycle.
- Latency: start accepted at edge N -> complete high in the cycle after edge N+DATA_W+1, i.e. 33 cycles for DATA_W=32, fixed and data-independent.
- Divide by zero: runs the full latency with no exception.
  - Unsigned: quotient = all ones, remainder = dividend.
  - Signed: magnitude result is then sign-fixed per the rules above (e.g. 7/0 -> q=0xFFFFFFFF, r=7).
- Signed overflow 0x80000000 / 0xFFFFFFFF: q=0x80000000, r=0. This is the natural result of magnitude arithmetic and needs no special case.
- sweap during RUN or DONE:
  - Next cycle state=IDLE, busy=0, complete=0.
  - quotient/remainder keep their previous values; a partially computed result is never written.
- Output timing: quotient/remainder change only on the DONE transition and are stable whenever complete=1.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the DATA_W default.
  - exe_ctrl bit positions for div and div_signed go in the same package, so decode and EX agree.
- One sub-module, div_step: a combinational single restoring iteration.
  - Inputs: rem, quo, divisor magnitude.
  - Outputs: next rem, next quo.
  - Instantiated once inside div_unit.

Test Plan:
- DIVU 100/7, start pulse one cycle -> complete exactly 33 cycles later, quotient=14, remainder=2; busy high for cycles 1..32.
- DIV -7/2 (0xFFFFFFF9, 2) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); DIV 7/-2 -> q=-3, r=1.
- DIV 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; DIVU 7/0 -> q=0xFFFFFFFF, r=7; latency unchanged.
- Start DIVU 50/5, assert sweap at cycle 10 -> busy=0 next cycle, no complete pulse, outputs keep the previous result. A new start at cycle 12 completes normally.
- div held high through a full operation -> only the first start is accepted. Start with sweap in the same cycle -> no operation begins.
- Assert resetn=0 asynchronously mid-RUN -> all outputs 0 immediately; after release, a fresh DIVU 9/3 gives q=3, r=0.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage divider: state encoding, default
// operand width and the exe_ctrl bit positions decode and EX agree on.
package div_unit_pkg;

    // Default operand/result width.
    localparam int DIV_DATA_W = 32;

    // Positions of the divider controls inside the exe_ctrl bundle.
    localparam int EXE_CTRL_DIV_BIT        = 0;
    localparam int EXE_CTRL_DIV_SIGNED_BIT = 1;

    // Divider sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage : div_unit_pkg

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem, quo} left,
// trial-subtract the divisor magnitude and keep the difference if it fits.
module div_step
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quo,
    input  logic [DATA_W-1:0] dvsr,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] quo_next
);

    logic [DATA_W:0]   shifted_s;
    logic [DATA_W-1:0] diff_s;
    logic              fits_s;

    // Shift, trial-subtract, and restore when the subtraction would go negative.
    // The remainder invariant (rem < dvsr) keeps the accepted difference
    // within DATA_W bits, so only the low bits of the subtraction are needed.
    always_comb begin
        shifted_s = {rem, quo[DATA_W-1]};
        fits_s    = (shifted_s >= {1'b0, dvsr});
        diff_s    = shifted_s[DATA_W-1:0] - dvsr;
        quo_next  = {quo[DATA_W-2:0], fits_s};
        if (fits_s) begin
            rem_next = diff_s;
        end else begin
            rem_next = shifted_s[DATA_W-1:0];
        end
    end

endmodule : div_step

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for the EX stage. Signed operations
// divide magnitudes and fix the signs at the end; the latency is fixed at
// DATA_W+1 cycles from acceptance to the complete pulse, data-independent.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              div,
    input  logic              div_signed,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    input  logic              sweap,
    output logic              busy,
    output logic              complete,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    div_state_e        state_r;
    logic [CNT_W-1:0]  count_r;
    logic [DATA_W-1:0] rem_r;
    logic [DATA_W-1:0] quo_r;
    logic [DATA_W-1:0] dvsr_r;
    logic              q_neg_r;
    logic              r_neg_r;
    logic              busy_r;
    logic              complete_r;
    logic [DATA_W-1:0] quotient_r;
    logic [DATA_W-1:0] remainder_r;

    logic [DATA_W-1:0] dvd_mag_s;
    logic [DATA_W-1:0] dvs_mag_s;
    logic              q_neg_s;
    logic              r_neg_s;
    logic [DATA_W-1:0] rem_next_s;
    logic [DATA_W-1:0] quo_next_s;
    logic [DATA_W-1:0] res_q_s;
    logic [DATA_W-1:0] res_r_s;

    // Operand magnitudes and result signs formed from the raw start operands.
    always_comb begin
        if (div_signed) begin
            if (dividend[DATA_W-1]) begin
                dvd_mag_s = {DATA_W{1'b0}} - dividend;
            end else begin
                dvd_mag_s = dividend;
            end
            if (divisor[DATA_W-1]) begin
                dvs_mag_s = {DATA_W{1'b0}} - divisor;
            end else begin
                dvs_mag_s = divisor;
            end
            q_neg_s = dividend[DATA_W-1] ^ divisor[DATA_W-1];
            r_neg_s = dividend[DATA_W-1];
        end else begin
            dvd_mag_s = dividend;
            dvs_mag_s = divisor;
            q_neg_s   = 1'b0;
            r_neg_s   = 1'b0;
        end
    end

    // Sign correction of the finished magnitude quotient and remainder.
    always_comb begin
        if (q_neg_r) begin
            res_q_s = {DATA_W{1'b0}} - quo_r;
        end else begin
            res_q_s = quo_r;
        end
        if (r_neg_r) begin
            res_r_s = {DATA_W{1'b0}} - rem_r;
        end else begin
            res_r_s = rem_r;
        end
    end

    div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .dvsr     (dvsr_r),
        .rem_next (rem_next_s),
        .quo_next (quo_next_s)
    );

    // Divider sequencer: capture on start, iterate in RUN, publish in DONE;
    // a flush returns to IDLE without touching the published results.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            count_r     <= {CNT_W{1'b0}};
            rem_r       <= {DATA_W{1'b0}};
            quo_r       <= {DATA_W{1'b0}};
            dvsr_r      <= {DATA_W{1'b0}};
            q_neg_r     <= 1'b0;
            r_neg_r     <= 1'b0;
            busy_r      <= 1'b0;
            complete_r  <= 1'b0;
            quotient_r  <= {DATA_W{1'b0}};
            remainder_r <= {DATA_W{1'b0}};
        end else if (sweap) begin
            state_r    <= ST_IDLE;
            count_r    <= {CNT_W{1'b0}};
            busy_r     <= 1'b0;
            complete_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    complete_r <= 1'b0;
                    if (div) begin
                        state_r <= ST_RUN;
                        count_r <= {CNT_W{1'b0}};
                        rem_r   <= {DATA_W{1'b0}};
                        quo_r   <= dvd_mag_s;
                        dvsr_r  <= dvs_mag_s;
                        q_neg_r <= q_neg_s;
                        r_neg_r <= r_neg_s;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    complete_r <= 1'b0;
                    rem_r      <= rem_next_s;
                    quo_r      <= quo_next_s;
                    count_r    <= count_r + CNT_W'(1);
                    if (count_r == CNT_W'(DATA_W - 1)) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    quotient_r  <= res_q_s;
                    remainder_r <= res_r_s;
                    complete_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    count_r     <= {CNT_W{1'b0}};
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    count_r    <= {CNT_W{1'b0}};
                    busy_r     <= 1'b0;
                    complete_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign complete  = complete_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;

endmodule : div_unit

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed operations with hand-computed
// results, plus a cycle-level reference model compared on every falling edge.
`timescale 1ns/1ps
module tb_div_unit;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         resetn = 1'b1;
    logic         div = 1'b0;
    logic         div_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         sweap = 1'b0;
    logic         busy;
    logic         complete;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    div_unit #(.DATA_W(W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .div        (div),
        .div_signed (div_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .sweap      (sweap),
        .busy       (busy),
        .complete   (complete),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clk = ~clk;

    // Reference arithmetic: returns {quotient, remainder}.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ma, mb, mq, mr;
        logic qn, rn;
        logic [31:0] q, r;
        if (s) begin
            ma = a[31] ? (64'h1_0000_0000 - 64'(a)) : 64'(a);
            mb = b[31] ? (64'h1_0000_0000 - 64'(b)) : 64'(b);
            qn = a[31] ^ b[31];
            rn = a[31];
        end else begin
            ma = 64'(a);
            mb = 64'(b);
            qn = 1'b0;
            rn = 1'b0;
        end
        if (mb == 0) begin
            mq = 64'hFFFF_FFFF;
            mr = ma;
        end else begin
            mq = ma / mb;
            mr = ma % mb;
        end
        q = qn ? (32'h0 - mq[31:0]) : mq[31:0];
        r = rn ? (32'h0 - mr[31:0]) : mr[31:0];
        return {q, r};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: an accepted start completes LAT edges later.
    int          m_left = 0;
    logic        m_busy = 1'b0;
    logic        m_cmp = 1'b0;
    logic [31:0] m_q = '0;
    logic [31:0] m_r = '0;
    logic [63:0] p_qr = '0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_left <= 0;
            m_busy <= 1'b0;
            m_cmp  <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
        end else begin
            m_cmp <= 1'b0;
            if (sweap) begin
                m_left <= 0;
                m_busy <= 1'b0;
            end else if (m_left == 0) begin
                if (div) begin
                    p_qr   <= ref_div(div_signed, dividend, divisor);
                    m_left <= LAT;
                    m_busy <= 1'b1;
                end
            end else if (m_left == 1) begin
                m_left <= 0;
                m_busy <= 1'b0;
                m_cmp  <= 1'b1;
                m_q    <= p_qr[63:32];
                m_r    <= p_qr[31:0];
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("complete", 32'(complete), 32'(m_cmp));
            chk("quotient", quotient, m_q);
            chk("remainder", remainder, m_r);
        end
    end

    // Issue one operation and check latency and hand-computed results.
    task automatic do_op(input string nm, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er);
        int k;
        @(negedge clk);
        div = 1'b1; div_signed = s; dividend = a; divisor = b;
        @(negedge clk);
        div = 1'b0;
        chk({nm, "_busy_early"}, 32'(busy), 32'd1);
        k = 0;
        while (!complete && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_latency"}, 32'(k), 32'(LAT));
        chk({nm, "_q"}, quotient, eq);
        chk({nm, "_r"}, remainder, er);
    endtask

    initial begin
        int k;
        #2 resetn = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_complete", 32'(complete), 32'd0);
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        chk_en = 1'b1;

        do_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        do_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        do_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        do_op("divu_7_0", 1'b0, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7);

        // Flush at cycle 10 of a DIVU 50/5, then restart at cycle 12.
        @(negedge clk);
        div = 1'b1; div_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
        @(negedge clk);
        div = 1'b0;
        repeat (8) @(negedge clk);
        sweap = 1'b1;
        @(negedge clk);
        sweap = 1'b0;
        chk("sweap_busy", 32'(busy), 32'd0);
        chk("sweap_keep_q", quotient, 32'hFFFF_FFFF);
        chk("sweap_keep_r", remainder, 32'd7);
        do_op("divu_50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0);

        // div held high with changing operands: only the first start counts.
        @(negedge clk);
        div = 1'b1; div_signed = 1'b0; dividend = 32'd1000; divisor = 32'd10;
        @(negedge clk);
        k = 0;
        while (!complete && k < 50) begin
            dividend = 32'(k) + 32'd3;
            divisor  = 32'd7;
            @(negedge clk);
            k++;
        end
        div = 1'b0;
        chk("hold_latency", 32'(k), 32'(LAT));
        chk("hold_q", quotient, 32'd100);
        chk("hold_r", remainder, 32'd0);

        // Start coinciding with a flush: nothing begins.
        @(negedge clk);
        div = 1'b1; sweap = 1'b1; dividend = 32'd9; divisor = 32'd3;
        @(negedge clk);
        div = 1'b0; sweap = 1'b0;
        repeat (3) begin
            chk("start_sweap_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end

        // Asynchronous reset mid-run.
        div = 1'b1; div_signed = 1'b0; dividend = 32'd1234; divisor = 32'd7;
        @(negedge clk);
        div = 1'b0;
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_complete", 32'(complete), 32'd0);
        chk("arst_q", quotient, 32'd0);
        chk("arst_r", remainder, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        do_op("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_div_unit
